// File: rtl/apb4_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module   : apb4_reg_bridge
// Purpose  : APB4 completer that forwards accesses inside a base-aligned
//            address window onto a simple register-bus request/ack interface.
//            It decodes the window, optionally rejects unprivileged writes,
//            honours downstream stalls, bounds the wait with a timeout, and
//            returns a registered APB response.
// Ports    : clk, rst (sync, active-high)
//            APB4 side : psel, penable, pwrite, paddr, pwdata, pstrb, pprot
//                        -> pready, pslverr, prdata (all registered)
//            Reg-bus   : bus_req, bus_req_is_wr, bus_addr, bus_wr_data,
//                        bus_wr_biten (registered outputs)
//                        <- bus_req_stall_wr, bus_req_stall_rd, bus_ready,
//                           bus_err, bus_rd_data
// Revision : 1.0 - initial release
// ============================================================================
module apb4_reg_bridge #(
    parameter int unsigned              PADDR_WIDTH     = 32,
    parameter int unsigned              ADDR_WIDTH      = 8,
    parameter int unsigned              DATA_WIDTH      = 32,
    parameter logic [PADDR_WIDTH-1:0]   BASE_ADDR       = '0,
    parameter int unsigned              TIMEOUT_CYCLES  = 16,
    parameter bit                       PRIV_WRITE_ONLY = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      psel,
    input  logic                      penable,
    input  logic                      pwrite,
    input  logic [PADDR_WIDTH-1:0]    paddr,
    input  logic [DATA_WIDTH-1:0]     pwdata,
    input  logic [DATA_WIDTH/8-1:0]   pstrb,
    input  logic [2:0]                pprot,
    output logic                      pready,
    output logic                      pslverr,
    output logic [DATA_WIDTH-1:0]     prdata,
    output logic                      bus_req,
    output logic                      bus_req_is_wr,
    output logic [ADDR_WIDTH-1:0]     bus_addr,
    output logic [DATA_WIDTH-1:0]     bus_wr_data,
    output logic [DATA_WIDTH-1:0]     bus_wr_biten,
    input  logic                      bus_req_stall_wr,
    input  logic                      bus_req_stall_rd,
    input  logic                      bus_ready,
    input  logic                      bus_err,
    input  logic [DATA_WIDTH-1:0]     bus_rd_data
);

    // Window size computed one bit wider than paddr so the top of the window
    // cannot wrap when BASE_ADDR sits near the end of the address space.
    localparam logic [PADDR_WIDTH:0] c_WIN_SIZE =
        {{PADDR_WIDTH{1'b0}}, 1'b1} << ADDR_WIDTH;
    localparam int unsigned c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST =
        c_CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    state_t                  r_state;
    logic                    r_pready;
    logic                    r_pslverr;
    logic [DATA_WIDTH-1:0]   r_prdata;
    logic                    r_bus_req;
    logic                    r_is_wr;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [DATA_WIDTH-1:0]   r_biten;
    logic [c_CNT_W-1:0]      r_cnt;
    logic                    r_abort;

    logic [PADDR_WIDTH:0]    w_off_ext;
    logic                    w_in_window;
    logic                    w_priv_block;
    logic [DATA_WIDTH-1:0]   w_biten;
    logic                    w_stall;
    logic                    w_done;
    logic                    w_timeout;
    logic                    w_abort;
    logic                    w_unused;

    assign w_off_ext    = {1'b0, paddr} - {1'b0, BASE_ADDR};
    assign w_in_window  = (paddr >= BASE_ADDR) && (w_off_ext < c_WIN_SIZE);
    assign w_priv_block = PRIV_WRITE_ONLY && pwrite && !pprot[0];

    for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_biten
        assign w_biten[gi] = pstrb[gi/8];
    end

    // Only the stall for the captured direction holds the request.
    assign w_stall   = r_is_wr ? bus_req_stall_wr : bus_req_stall_rd;
    // An ack seen while the request is still stalled has not been accepted.
    assign w_done    = (bus_ready || bus_err) && ((r_state == ST_WAIT) || !w_stall);
    assign w_timeout = (TIMEOUT_CYCLES != 0) && (r_cnt == c_CNT_LAST);
    // Includes the current cycle so a response is never raised into psel=0.
    assign w_abort   = r_abort || !psel;
    assign w_unused  = ^pprot[2:1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pready  <= 1'b0;
            r_pslverr <= 1'b0;
            r_prdata  <= '0;
            r_bus_req <= 1'b0;
            r_is_wr   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_biten   <= '0;
            r_cnt     <= '0;
            r_abort   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (psel && !penable) begin
                        r_is_wr <= pwrite;
                        r_addr  <= w_off_ext[ADDR_WIDTH-1:0];
                        r_wdata <= pwdata;
                        r_biten <= w_biten;
                        r_cnt   <= '0;
                        r_abort <= 1'b0;
                        if (!w_in_window || w_priv_block) begin
                            // Rejected locally: the register block never sees it.
                            r_state   <= ST_RESP;
                            r_pready  <= 1'b1;
                            r_pslverr <= 1'b1;
                            r_prdata  <= '0;
                        end else begin
                            r_state   <= ST_REQ;
                            r_bus_req <= 1'b1;
                        end
                    end
                end

                ST_REQ, ST_WAIT: begin
                    if (w_done || w_timeout) begin
                        r_bus_req <= 1'b0;
                        r_abort   <= 1'b0;
                        if (w_abort) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_state  <= ST_RESP;
                            r_pready <= 1'b1;
                            if (w_done) begin
                                r_pslverr <= bus_err;
                                r_prdata  <= r_is_wr ? '0 : bus_rd_data;
                            end else begin
                                r_pslverr <= 1'b1;
                                r_prdata  <= '0;
                            end
                        end
                    end else begin
                        r_cnt   <= r_cnt + 1'b1;
                        r_abort <= w_abort;
                        if ((r_state == ST_REQ) && !w_stall) begin
                            r_state   <= ST_WAIT;
                            r_bus_req <= 1'b0;
                        end
                    end
                end

                ST_RESP: begin
                    r_state   <= ST_IDLE;
                    r_pready  <= 1'b0;
                    r_pslverr <= 1'b0;
                    r_prdata  <= '0;
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign pready        = r_pready;
    assign pslverr       = r_pslverr;
    assign prdata        = r_prdata;
    assign bus_req       = r_bus_req;
    assign bus_req_is_wr = r_is_wr;
    assign bus_addr      = r_addr;
    assign bus_wr_data   = r_wdata;
    assign bus_wr_biten  = r_biten;

endmodule
`default_nettype wire

// File: tb/tb_apb4_reg_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_apb4_reg_bridge
// Purpose  : Scoreboard bench for apb4_reg_bridge. A driver issues APB
//            transfers and plays the register block; expected APB responses
//            and expected register-bus requests are queued from a reference
//            model, and an independent monitor checks them as they appear.
// Revision : 1.0 - initial release
// ============================================================================
module tb_apb4_reg_bridge;

    localparam logic [31:0] BASE = 32'h4000_1000;
    localparam int          TMO  = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        psel, penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic        pready, pslverr;
    logic [31:0] prdata;
    logic        bus_req, bus_req_is_wr;
    logic [7:0]  bus_addr;
    logic [31:0] bus_wr_data, bus_wr_biten;
    logic        bus_req_stall_wr, bus_req_stall_rd, bus_ready, bus_err;
    logic [31:0] bus_rd_data;

    apb4_reg_bridge #(
        .PADDR_WIDTH(32), .ADDR_WIDTH(8), .DATA_WIDTH(32), .BASE_ADDR(BASE),
        .TIMEOUT_CYCLES(TMO), .PRIV_WRITE_ONLY(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .pready(pready), .pslverr(pslverr), .prdata(prdata),
        .bus_req(bus_req), .bus_req_is_wr(bus_req_is_wr), .bus_addr(bus_addr),
        .bus_wr_data(bus_wr_data), .bus_wr_biten(bus_wr_biten),
        .bus_req_stall_wr(bus_req_stall_wr), .bus_req_stall_rd(bus_req_stall_rd),
        .bus_ready(bus_ready), .bus_err(bus_err), .bus_rd_data(bus_rd_data)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] data; logic err; } resp_t;
    typedef struct packed { logic wr; logic [7:0] addr; logic [31:0] wdata; logic [31:0] biten; } busx_t;

    resp_t resp_q[$];
    busx_t bus_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic busx_t mk_bus(input logic wr, input logic [31:0] a,
                                     input logic [31:0] wd, input logic [3:0] s);
        busx_t b;
        b.wr    = wr;
        b.addr  = 8'(a - BASE);
        b.wdata = wd;
        b.biten = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        return b;
    endfunction

    task automatic clear_bus_inputs();
        bus_req_stall_wr = 1'b0; bus_req_stall_rd = 1'b0;
        bus_ready = 1'b0; bus_err = 1'b0; bus_rd_data = '0;
    endtask

    // One APB transfer with a scripted register-block behaviour:
    // stall cycles, ack delay after acceptance, missing ack, error ack.
    task automatic do_xfer(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] s, input logic [2:0] prot,
                           input int stall, input bit stall_other, input int delay,
                           input bit noack, input bit berr, input logic [31:0] rd,
                           input int pen_at);
        bit    hit, fwd;
        int    eff_s, cc, exp_cp, exp_req, cp, req_cycles, pa;
        resp_t r;
        hit = (a >= BASE) && ((a - BASE) < 32'd256);
        fwd = hit && !(wr && !prot[0]);
        pa  = fwd ? pen_at : 1;
        tick();
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a;
        pwdata = wd; pstrb = s; pprot = prot;
        eff_s = stall_other ? 0 : stall;
        cc    = eff_s + 1 + delay;
        if (!fwd) begin
            r = '{data: 32'd0, err: 1'b1};
            exp_cp = 1; exp_req = 0;
        end else begin
            bus_q.push_back(mk_bus(wr, a, wd, s));
            if (!noack && cc <= TMO) begin
                r = '{data: (wr ? 32'd0 : rd), err: berr};
                exp_cp = cc + 1;
            end else begin
                r = '{data: 32'd0, err: 1'b1};
                exp_cp = TMO + 1;
            end
            exp_req = (eff_s + 1 < TMO) ? eff_s + 1 : TMO;
        end
        resp_q.push_back(r);
        cp = 0; req_cycles = 0;
        for (int c = 1; c <= 40 && cp == 0; c++) begin
            tick();
            penable = (c >= pa);
            if (fwd) begin
                bus_req_stall_wr = (wr ^ stall_other) && (c <= stall);
                bus_req_stall_rd = !(wr ^ stall_other) && (c <= stall);
                bus_ready   = !noack && !berr && (c == cc);
                bus_err     = !noack && berr && (c == cc);
                bus_rd_data = (c == cc) ? rd : $urandom;
            end
            @(negedge clk);
            if (bus_req) req_cycles++;
            if (pready) cp = c;
        end
        check("pready_latency", 64'(cp), 64'(exp_cp));
        check("bus_req_cycles", 64'(req_cycles), 64'(exp_req));
        tick();
        psel = 1'b0; penable = 1'b0;
        clear_bus_inputs();
    endtask

    // Watches n idle cycles; any pready or bus_req is counted as a hit.
    task automatic idle_watch(input int n, output int hits);
        hits = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (pready || bus_req) hits++;
            tick();
            bus_ready = 1'b0; bus_err = 1'b0;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, {52'd0, pready, pslverr, bus_req, bus_req_is_wr, bus_addr}, 64'd0);
        check({tag, "_data"}, {prdata, bus_wr_data}, 64'd0);
        check({tag, "_biten"}, 64'(bus_wr_biten), 64'd0);
    endtask

    // Monitor: compares every response and every new bus request against the queues.
    initial begin : monitor
        logic prev_req;
        resp_t r;
        busx_t b;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (pready) begin
                    check("pready_with_psel", 64'(psel), 64'd1);
                    if (resp_q.size() == 0) begin
                        check("unexpected_pready", 64'(pready), 64'd0);
                    end else begin
                        r = resp_q.pop_front();
                        check("prdata", 64'(prdata), 64'(r.data));
                        check("pslverr", 64'(pslverr), 64'(r.err));
                    end
                end
                if (bus_req && !prev_req) begin
                    if (bus_q.size() == 0) begin
                        check("unexpected_bus_req", 64'(bus_req), 64'd0);
                    end else begin
                        b = bus_q.pop_front();
                        check("bus_req_is_wr", 64'(bus_req_is_wr), 64'(b.wr));
                        check("bus_addr", 64'(bus_addr), 64'(b.addr));
                        if (b.wr) begin
                            check("bus_wr_data", 64'(bus_wr_data), 64'(b.wdata));
                            check("bus_wr_biten", 64'(bus_wr_biten), 64'(b.biten));
                        end
                    end
                end
            end
            prev_req = bus_req;
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int hits;
        rst = 1'b1; psel = 0; penable = 0; pwrite = 0; paddr = '0;
        pwdata = '0; pstrb = '0; pprot = '0;
        clear_bus_inputs();
        repeat (3) tick();
        @(negedge clk);
        check_all_zero("reset");
        tick();
        rst = 1'b0;

        // Write with byte strobes, ack in the request cycle.
        do_xfer(1, BASE + 32'h04, 32'hA5A5_0001, 4'b0011, 3'b001, 0, 0, 0, 0, 0, 32'h0, 1);
        // Read, ack three cycles after the request.
        do_xfer(0, BASE + 32'h10, 32'h0, 4'hF, 3'b000, 0, 0, 3, 0, 0, 32'hDEAD_BEEF, 1);
        // Read stalled for five cycles, then completes.
        do_xfer(0, BASE + 32'h14, 32'h0, 4'hF, 3'b000, 5, 0, 0, 0, 0, 32'h1234_5678, 1);
        // Stall raised on the other direction only: must not hold the write.
        do_xfer(1, BASE + 32'h18, 32'hCAFE_F00D, 4'b1100, 3'b001, 5, 1, 2, 0, 0, 32'h0, 1);
        // No ack: timeout, then a late ack in IDLE must be ignored.
        do_xfer(0, BASE + 32'h20, 32'h0, 4'hF, 3'b000, 0, 0, 0, 1, 0, 32'h0, 1);
        bus_ready = 1'b1; bus_rd_data = 32'h5555_AAAA;
        idle_watch(3, hits);
        check("late_ack_ignored", 64'(hits), 64'd0);
        // Out-of-window accesses above and below.
        do_xfer(0, BASE + 32'h100, 32'h0, 4'hF, 3'b000, 0, 0, 0, 0, 0, 32'h0, 1);
        do_xfer(1, BASE - 32'h4, 32'h1, 4'hF, 3'b001, 0, 0, 0, 0, 0, 32'h0, 1);
        do_xfer(0, BASE + 32'hFC, 32'h0, 4'hF, 3'b000, 0, 0, 1, 0, 0, 32'h0BAD_CAFE, 1);
        // Privilege filter: unprivileged write rejected, privileged accepted.
        do_xfer(1, BASE + 32'h08, 32'h1111_2222, 4'hF, 3'b000, 0, 0, 0, 0, 0, 32'h0, 1);
        do_xfer(1, BASE + 32'h08, 32'h3333_4444, 4'hF, 3'b001, 0, 0, 1, 0, 0, 32'h0, 1);
        // Error completion on a read keeps the returned data.
        do_xfer(0, BASE + 32'h30, 32'h0, 4'hF, 3'b000, 0, 0, 2, 0, 1, 32'h7777_0000, 1);
        // Late penable does not change latency.
        do_xfer(0, BASE + 32'h34, 32'h0, 4'hF, 3'b000, 0, 0, 0, 0, 0, 32'h8888_9999, 2);

        // psel dropped mid-transfer: downstream completes, no APB response.
        tick();
        psel = 1; penable = 0; pwrite = 0; paddr = BASE + 32'h40; pprot = 0;
        bus_q.push_back(mk_bus(0, BASE + 32'h40, pwdata, pstrb));
        hits = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (c == 1) penable = 1;
            if (c == 2) begin psel = 0; penable = 0; end
            bus_ready = (c == 5);
            bus_rd_data = $urandom;
            @(negedge clk);
            if (pready) hits++;
        end
        check("abort_no_pready", 64'(hits), 64'd0);
        clear_bus_inputs();

        // Reset while waiting for the ack.
        tick();
        psel = 1; penable = 0; pwrite = 0; paddr = BASE + 32'h44; pprot = 0;
        bus_q.push_back(mk_bus(0, BASE + 32'h44, pwdata, pstrb));
        tick(); penable = 1;
        tick();
        tick(); rst = 1;
        tick(); rst = 0; psel = 0; penable = 0;
        @(negedge clk);
        check_all_zero("mid_reset");
        idle_watch(2, hits);
        check("post_reset_idle", 64'(hits), 64'd0);

        // Randomised traffic.
        for (int n = 0; n < 60; n++) begin
            logic [31:0] a;
            int sel, st, dl;
            sel = int'($urandom_range(0, 9));
            if (sel < 8)       a = BASE + $urandom_range(0, 255);
            else if (sel == 8) a = BASE + 32'd256 + $urandom_range(0, 4095);
            else               a = BASE - 32'd1 - $urandom_range(0, 4095);
            if ($urandom_range(0, 14) == 0)     st = 18;
            else if ($urandom_range(0, 2) == 0) st = int'($urandom_range(1, 6));
            else                                st = 0;
            dl = int'($urandom_range(0, 5));
            do_xfer($urandom_range(0, 1) == 1, a, $urandom, 4'($urandom), 3'($urandom),
                    st, $urandom_range(0, 3) == 0, dl, $urandom_range(0, 11) == 0,
                    $urandom_range(0, 7) == 0, $urandom, int'($urandom_range(1, 2)));
        end

        repeat (3) tick();
        check("resp_queue_drained", 64'(resp_q.size()), 64'd0);
        check("bus_queue_drained", 64'(bus_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
